// File: rtl/lstm_inpdt_mac.sv
// ---------------------------------------------------------------------------
// lstm_inpdt_mac
//
// Streaming multiply-accumulate engine that builds the signed 32-bit inner
// product consumed by the LSTM bias/requantization stages. Pairs of 8-bit
// asymmetric-quantized weight/data bytes arrive on a valid/ready stream. The
// block removes the zero points and multiplies each pair (stage 1). It then
// accumulates the products (stage 2) over a vector of programmable length.
// The sum is presented behind a valid/ready output handshake.
//
// Handshake semantics (both streams): a transfer happens on a rising clock
// edge where valid and ready are both high. valid never depends on ready.
// The producer holds its payload until the transfer. A payload presented while
// ready is low is not consumed.
//
// Ports:
//   clk          - sole clock, rising edge
//   rstn         - asynchronous active-low reset
//   start        - single-cycle request to begin a vector (IDLE only)
//   len          - number of element pairs, sampled with an honoured start
//   in_valid     - w_in/x_in carry a pair
//   in_ready     - a pair is accepted this cycle
//   w_in, x_in   - unsigned quantized weight / data
//   out_valid    - inpdt_R_reg holds the final sum
//   out_ready    - consumer takes the result
//   inpdt_R_reg  - signed two's-complement accumulated sum
//   busy         - high in every state except IDLE
//   dbg_state    - current FSM state encoding (IDLE=0 ACC=1 DRAIN=2 DONE=3)
// ---------------------------------------------------------------------------
module lstm_inpdt_mac #(
  parameter logic [7:0] ZERO_W    = 8'd128,
  parameter logic [7:0] ZERO_DATA = 8'd128,
  parameter int         LEN_W     = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       w_in,
  input  logic [7:0]       x_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inpdt_R_reg,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t             state;
  state_t             state_nxt;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;
  logic signed [17:0] p;
  logic               p_vld;
  logic [31:0]        acc;

  logic               hs;
  logic               vec_go;
  logic               zero_go;
  logic signed [8:0]  dw;
  logic signed [8:0]  dx;
  logic signed [17:0] prod;

  // Zero-point removal: both operands widened to 9 bits so the difference
  // covers -255..+255 without wrap.
  assign dw   = $signed({1'b0, w_in}) - $signed({1'b0, ZERO_W});
  assign dx   = $signed({1'b0, x_in}) - $signed({1'b0, ZERO_DATA});
  assign prod = dw * dx;

  assign in_ready    = (state == ACC) && (cnt < len_q);
  assign hs          = in_valid && in_ready;
  assign inpdt_R_reg = acc;
  assign dbg_state   = state;

  // Next-state and output decode.
  always_comb begin
    state_nxt = state;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    vec_go    = 1'b0;
    zero_go   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len != '0) begin
            vec_go    = 1'b1;
            state_nxt = ACC;
          end else begin
            zero_go   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ACC: begin
        if (hs && ((cnt + ONE) == len_q)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last product lands in the accumulator on the edge that clears
        // p_vld, so leaving once p_vld is low means the sum is complete.
        if (!p_vld) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
      len_q <= '0;
      p     <= '0;
      p_vld <= 1'b0;
      acc   <= '0;
    end else begin
      state <= state_nxt;
      p_vld <= hs;
      if (hs) begin
        p   <= prod;
        cnt <= cnt + ONE;
      end
      // hs only occurs in ACC and vec_go/zero_go only in IDLE, and no
      // product is pending in IDLE, so these branches never collide.
      if (vec_go) begin
        len_q <= len;
        cnt   <= '0;
        acc   <= '0;
      end else if (zero_go) begin
        len_q <= '0;
        cnt   <= '0;
        acc   <= '0;
      end else if (p_vld) begin
        acc <= acc + {{14{p[17]}}, p};
      end
    end
  end

endmodule

// File: tb/tb_lstm_inpdt_mac.sv
// ---------------------------------------------------------------------------
// tb_lstm_inpdt_mac
//
// Directed bench for lstm_inpdt_mac. Pairs for a vector are staged in w_q/x_q.
// The expected sum comes from a reference formula and is pushed to exp_q when
// the vector is started. It is popped and compared when the DUT presents
// out_valid. Inputs are driven 1ns after the rising edge, and outputs are
// sampled at that same point before new inputs are applied.
// ---------------------------------------------------------------------------
module tb_lstm_inpdt_mac;

  localparam int LEN_W = 10;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       w_in = '0;
  logic [7:0]       x_in = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      inpdt_R_reg;
  logic             busy;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  lstm_inpdt_mac #(
    .ZERO_W   (8'd128),
    .ZERO_DATA(8'd128),
    .LEN_W    (LEN_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .len        (len),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w_in       (w_in),
    .x_in       (x_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .inpdt_R_reg(inpdt_R_reg),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  w_q[$];
  logic [7:0]  x_q[$];
  logic        vpat[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pairs(input int n, input logic [7:0] w, input logic [7:0] x);
    for (int i = 0; i < n; i++) begin
      w_q.push_back(w);
      x_q.push_back(x);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Computes the reference sum of the staged pairs, pushes it, pulses start.
  task automatic start_vec(input int n);
    int s;
    s = 0;
    foreach (w_q[i]) s += (int'(w_q[i]) - 128) * (int'(x_q[i]) - 128);
    exp_q.push_back(s);
    start = 1'b1;
    len   = n[LEN_W-1:0];
    tick();
    start = 1'b0;
    len   = '0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("in_ready_after_start", {31'd0, in_ready}, (n != 0) ? 32'd1 : 32'd0);
  endtask

  // Streams staged pairs using vpat as the in_valid pattern (1 once exhausted).
  // A start with len=2 is injected while exactly inject_at pairs are accepted.
  task automatic feed(input int inject_at);
    int   accepts;
    int   budget;
    int   pi;
    logic took;
    accepts = 0;
    budget  = 0;
    pi      = 0;
    while (w_q.size() > 0 && budget < 200) begin
      in_valid = (pi < vpat.size()) ? vpat[pi] : 1'b1;
      pi++;
      w_in = w_q[0];
      x_in = x_q[0];
      if (inject_at >= 0 && accepts == inject_at) begin
        start = 1'b1;
        len   = 10'd2;
      end
      took = in_valid && in_ready;
      tick();
      start = 1'b0;
      len   = '0;
      if (took) begin
        w_q.delete(0);
        x_q.delete(0);
        accepts++;
      end
      budget++;
    end
    in_valid = 1'b0;
    vpat.delete();
    check("feed_not_timed_out", {31'd0, (budget < 200)}, 32'd1);
    // now just after the last accept edge T
    check("in_ready_after_last", {31'd0, in_ready}, 32'd0);
    check("out_valid_at_T", {31'd0, out_valid}, 32'd0);
    tick();
    check("out_valid_at_T1", {31'd0, out_valid}, 32'd0);
    tick();
    check("out_valid_at_T2", {31'd0, out_valid}, 32'd1);
  endtask

  // Waits (bounded) for out_valid, holds out_ready low for hold cycles, then
  // completes the handshake with a start in the same cycle.
  task automatic collect(input int hold);
    int          waited;
    logic [31:0] expv;
    waited = 0;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    check("out_valid_seen", {31'd0, out_valid}, 32'd1);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    for (int i = 0; i < hold; i++) begin
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", inpdt_R_reg, expv);
      tick();
    end
    check("result", inpdt_R_reg, expv);
    start     = 1'b1;
    len       = 10'd3;
    out_ready = 1'b1;
    tick();
    start     = 1'b0;
    len       = '0;
    out_ready = 1'b0;
    check("idle_after_take_busy", {31'd0, busy}, 32'd0);
    check("idle_after_take_out_valid", {31'd0, out_valid}, 32'd0);
    check("result_kept_after_take", inpdt_R_reg, expv);
    tick();
    check("start_at_take_ignored", {30'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", inpdt_R_reg, 32'd0);
    tick();
    rstn = 1'b1;
    tick();

    // len=1, dw=1, dx=2 -> 2
    load_pairs(1, 8'd129, 8'd130);
    start_vec(1);
    feed(-1);
    collect(0);

    // len=4, w=0, x=0 -> 4*16384
    load_pairs(4, 8'd0, 8'd0);
    start_vec(4);
    feed(-1);
    collect(0);

    // len=3, w=0, x=255 -> negative sum, sign extension
    load_pairs(3, 8'd0, 8'd255);
    start_vec(3);
    feed(-1);
    collect(0);

    // len=0: immediate zero result
    start_vec(0);
    check("len0_out_valid", {31'd0, out_valid}, 32'd1);
    collect(0);

    // len=5 with in_valid gaps 1,0,0,1,1,0,1,1
    load_pairs(5, 8'd128, 8'd77);
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    start_vec(5);
    feed(-1);
    collect(0);

    // len=8 with a start injected mid-vector, then a 10-cycle stall in DONE
    for (int i = 0; i < 8; i++) begin
      w_q.push_back(8'(100 + 7 * i));
      x_q.push_back(8'(200 - 13 * i));
    end
    start_vec(8);
    feed(3);
    collect(10);

    // len=8, reset after the 3rd accept
    load_pairs(8, 8'd129, 8'd129);
    start_vec(8);
    in_valid = 1'b1;
    w_in     = 8'd129;
    x_in     = 8'd129;
    tick();
    tick();
    tick();
    rstn = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", inpdt_R_reg, 32'd0);
    check("midrst_state", {30'd0, dbg_state}, 32'd0);
    in_valid = 1'b0;
    void'(exp_q.pop_back());
    w_q.delete();
    x_q.delete();
    tick();
    rstn = 1'b1;
    tick();

    // fresh len=2 after reset: (130,126) -> -4, (128,128) -> 0
    w_q.push_back(8'd130); x_q.push_back(8'd126);
    w_q.push_back(8'd128); x_q.push_back(8'd128);
    start_vec(2);
    feed(-1);
    collect(0);

    // random vector with random gaps
    begin
      int n;
      n = $urandom_range(20, 10);
      for (int i = 0; i < n; i++) begin
        w_q.push_back(8'($urandom_range(255, 0)));
        x_q.push_back(8'($urandom_range(255, 0)));
      end
      for (int i = 0; i < 30; i++) vpat.push_back(1'($urandom_range(1, 0)));
      start_vec(n);
      feed(-1);
      collect(2);
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
